// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: holds the PLL in reset, waits for a stable lock,
// delays SoC reset release, and retries or faults on lock timeout.
module pll_reset_sequencer #(
  parameter int POR_CYCLES   = 127,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int SOC_DELAY    = 256,
  parameter int MAX_RETRY    = 3
) (
  input  logic       EXT_CLK_50MHz,
  input  logic       BTN_RESET_n,
  input  logic       pll_locked_in,
  output logic       pll_areset,
  output logic       soc_reset_n,
  output logic [2:0] seq_state,
  output logic [7:0] lock_loss_count,
  output logic       fault
);

  localparam logic [2:0] S_POR   = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_SOC   = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  // One shared phase counter, wide enough for the longest phase.
  localparam int CNT_MAX = (POR_CYCLES > LOCK_TIMEOUT) ?
                           ((POR_CYCLES > SOC_DELAY) ? POR_CYCLES : SOC_DELAY) :
                           ((LOCK_TIMEOUT > SOC_DELAY) ? LOCK_TIMEOUT : SOC_DELAY);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int STAB_W  = $clog2(LOCK_STABLE + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   POR_LAST   = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   SOC_LAST   = CNT_W'(SOC_DELAY - 1);
  localparam logic [STAB_W-1:0]  STAB_LAST  = STAB_W'(LOCK_STABLE - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

  logic               sync1_q, lock_s;
  logic [2:0]         st_q, st_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STAB_W-1:0]  stab_q, stab_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [7:0]         llc_q, llc_d;
  logic               areset_q, areset_d, socn_q, socn_d, fault_q, fault_d;

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    stab_d   = stab_q;
    retry_d  = retry_q;
    llc_d    = llc_q;
    areset_d = areset_q;
    socn_d   = socn_q;
    fault_d  = fault_q;
    case (st_q)
      S_POR: begin
        stab_d = '0;
        if (cnt_q == POR_LAST) begin
          st_d     = S_WAIT;
          cnt_d    = '0;
          areset_d = 1'b0;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_WAIT: begin
        stab_d = lock_s ? stab_q + 1'b1 : '0;
        // Acceptance is tested first so it wins over a coincident timeout.
        if (lock_s && stab_q == STAB_LAST) begin
          st_d    = S_SOC;
          cnt_d   = '0;
          stab_d  = '0;
          retry_d = '0;
        end else if (cnt_q == TO_LAST) begin
          retry_d  = retry_q + 1'b1;
          cnt_d    = '0;
          stab_d   = '0;
          areset_d = 1'b1;
          if (retry_q == RETRY_LAST) begin
            st_d    = S_FAULT;
            fault_d = 1'b1;
          end else st_d = S_POR;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_SOC: begin
        if (!lock_s) begin
          st_d     = S_POR;
          cnt_d    = '0;
          areset_d = 1'b1;
        end else if (cnt_q == SOC_LAST) begin
          st_d   = S_RUN;
          cnt_d  = '0;
          socn_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_RUN: begin
        if (!lock_s) begin
          st_d     = S_POR;
          cnt_d    = '0;
          areset_d = 1'b1;
          socn_d   = 1'b0;
          if (llc_q != 8'hFF) llc_d = llc_q + 1'b1;
        end
      end
      S_FAULT: ;
      default: begin
        st_d     = S_POR;
        cnt_d    = '0;
        stab_d   = '0;
        areset_d = 1'b1;
        socn_d   = 1'b0;
        fault_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge EXT_CLK_50MHz) begin
    if (!BTN_RESET_n) begin
      sync1_q  <= 1'b0;
      lock_s   <= 1'b0;
      st_q     <= S_POR;
      cnt_q    <= '0;
      stab_q   <= '0;
      retry_q  <= '0;
      llc_q    <= '0;
      areset_q <= 1'b1;
      socn_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      sync1_q  <= pll_locked_in;
      lock_s   <= sync1_q;
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      stab_q   <= stab_d;
      retry_q  <= retry_d;
      llc_q    <= llc_d;
      areset_q <= areset_d;
      socn_q   <= socn_d;
      fault_q  <= fault_d;
    end
  end

  assign pll_areset      = areset_q;
  assign soc_reset_n     = socn_q;
  assign fault           = fault_q;
  assign seq_state       = st_q;
  assign lock_loss_count = llc_q;

endmodule
